fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0: fetch and decode address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 16: byte-queue capacity; power of two, at least 8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fetch_pc  output  32  byte address driven to instr_mem.pc.
REQ-006 SHALL have port fetch_instr  input  40  instr_mem.instr, combinational, little-endian: byte i at [8i+7:8i] is mem[fetch_pc+i].
REQ-007 SHALL have port fetch_en  input  1  when 0, no fill occurs.
REQ-008 SHALL have port dec_bytes  output  40  head 5 queue bytes, little-endian: head byte at [7:0]; invalid lanes 0.
REQ-009 SHALL have port dec_count  output  3  valid head bytes, min(count,5).
REQ-010 SHALL have port dec_pc  output  32  address of the head byte.
REQ-011 SHALL have port dec_take  input  3  bytes consumed by decode this cycle, 0..5.
REQ-012 SHALL have port redirect_valid  input  1  flush-and-refetch request.
REQ-013 SHALL have port redirect_pc  input  32  new fetch address.
REQ-014 SHALL have port take_err  output  1  sticky flag: over-consumption seen.

Function
REQ-015 SHALL keep state: byte array[DEPTH], head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of 0..DEPTH, fetch_pc, dec_pc, take_err.
REQ-016 SHALL fill when fetch_en=1, redirect_valid=0 and DEPTH-count>=5 (current-cycle count): write fetch_instr bytes 0..4 at tail..tail+4 mod DEPTH; tail+=5; fetch_pc+=5 mod 2^32.
REQ-017 SHALL compute eff_take=min(dec_take,dec_count); head+=eff_take; dec_pc+=eff_take mod 2^32.
REQ-018 SHALL set take_err when dec_take>dec_count and redirect_valid=0; it holds until reset.
REQ-019 SHALL update on fill and take in the same cycle: count_next = count + (fill?5:0) - eff_take.
REQ-020 SHALL drive dec_bytes, dec_count and dec_pc from registered state only: zero-cycle read, one-cycle fill-to-visible latency.
REQ-021 SHALL on redirect_valid=1 ignore fill and dec_take; next cycle count=0, head=tail=0, fetch_pc=dec_pc=redirect_pc.
REQ-022 SHALL keep dec_take=0 harmless when count=0 (dec_count=0, dec_bytes=0).

Reset
REQ-023 SHALL on rst_n=0 at a clock edge set count=0, head=tail=0, fetch_pc=dec_pc=RESET_PC, take_err=0, dec_bytes=0 and dec_count=0; reset overrides redirect, fill and take.
REQ-024 SHALL not clear array contents on reset; they are unobservable while count=0.

Structure
REQ-025 SHALL place FQ_WIN=5 and the default DEPTH in shared package fetch_pkg.
REQ-026 SHALL implement byte storage and the 5-lane wrapped read/write in sub-module fq_byte_ring; pointer, count and PC control stay in fetch_queue.

Verification
Memory image mem[k]=k for every test, as in test_mem.hex.
REQ-027 SHALL test reset, fetch_en=1, dec_take=0: fills at fetch_pc 0, 5, 10; stops at count 15 with fetch_pc=15; dec_bytes=40'h0403020100, dec_count=5, dec_pc=0.
REQ-028 SHALL test steady dec_take=3 after prefill: dec_pc 0, 3, 6, ...; at dec_pc=3 dec_bytes=40'h0706050403; count never exceeds DEPTH.
REQ-029 SHALL test redirect_valid with redirect_pc=32'h21 plus dec_take=2 on a full queue: next cycle dec_count=0, fetch_pc=32'h21, dec_pc=32'h21; one cycle later dec_bytes=40'h2524232221, dec_count=5.
REQ-030 SHALL test dec_count=2 with dec_take=5: only 2 bytes consumed, dec_pc+=2, take_err=1 and stays 1 until rst_n=0.
REQ-031 SHALL test continuous dec_take=5 for 40 cycles: pointers wrap; at every cycle with dec_count=5, dec_bytes byte i equals (dec_pc+i)&8'hFF.
REQ-032 SHALL test rst_n=0 mid-stream with count=12: next cycle count=0, fetch_pc=dec_pc=RESET_PC, take_err=0, dec_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  // Bytes delivered by one instruction-memory read and offered to decode per cycle.
  localparam int FQ_WIN   = 5;
  // Default byte-queue capacity.
  localparam int FQ_DEPTH = 16;

endpackage : fetch_pkg

// File: rtl/fq_byte_ring.sv
// Byte ring storage: 5-lane wrapped write at wr_ptr, 5-lane wrapped read at rd_ptr.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here; the caller decides when to write and which lanes are valid.
module fq_byte_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PW-1:0]         wr_ptr,
  input  logic [8*FQ_WIN-1:0]   wr_dat,
  input  logic [PW-1:0]         rd_ptr,
  output logic [8*FQ_WIN-1:0]   rd_dat
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next array image: lane i lands at wr_ptr+i, the PW-bit sum wraps modulo DEPTH.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < FQ_WIN; i++) begin
        mem_d[wr_ptr + PW'(i)] = wr_dat[8*i +: 8];
      end
    end
  end

  // Storage is deliberately not reset: contents are never exposed while the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Raw 5-byte window starting at rd_ptr; lane masking is done by the owner of the count.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < FQ_WIN; i++) begin
      rd_dat[8*i +: 8] = mem_q[rd_ptr + PW'(i)];
    end
  end

endmodule : fq_byte_ring

// File: rtl/fetch_queue.sv
// Instruction byte queue between a 5-byte-wide instruction memory and a variable-length decoder.
// Latency: fill visible to decode one cycle later; decode window is read straight from registers.
// Backpressure: fill stalls while fewer than 5 slots are free; decode over-take is clipped and flagged.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = FQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_pc,
  input  logic [39:0] fetch_instr,
  input  logic        fetch_en,
  output logic [39:0] dec_bytes,
  output logic [2:0]  dec_count,
  output logic [31:0] dec_pc,
  input  logic [2:0]  dec_take,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        take_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   dec_pc_q, dec_pc_d;
  logic          take_err_q, take_err_d;

  logic          fill;
  logic          over_take;
  logic [2:0]    eff_take;
  logic [39:0]   ring_rd;

  fq_byte_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk    (clk),
    .wr_en  (fill & rst_n),
    .wr_ptr (tail_q),
    .wr_dat (fetch_instr),
    .rd_ptr (head_q),
    .rd_dat (ring_rd)
  );

  // Decode view: clip the count to the window and zero lanes beyond it.
  always_comb begin
    dec_count = (count_q >= CW'(FQ_WIN)) ? 3'(FQ_WIN) : count_q[2:0];
    dec_bytes = '0;
    for (int i = 0; i < FQ_WIN; i++) begin
      if (3'(i) < dec_count) begin
        dec_bytes[8*i +: 8] = ring_rd[8*i +: 8];
      end
    end
  end

  // Fill and take decisions, all from current-cycle registered state.
  always_comb begin
    fill      = fetch_en && !redirect_valid && ((CW'(DEPTH) - count_q) >= CW'(FQ_WIN));
    over_take = dec_take > dec_count;
    eff_take  = over_take ? dec_count : dec_take;
  end

  // Pointer/count/PC next state; redirect flushes and wins over fill and take.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    dec_pc_d   = dec_pc_q;
    take_err_d = take_err_q;
    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      dec_pc_d   = redirect_pc;
    end else begin
      if (fill) begin
        tail_d     = tail_q + PW'(FQ_WIN);
        fetch_pc_d = fetch_pc_q + 32'(FQ_WIN);
      end
      head_d   = head_q + PW'(eff_take);
      dec_pc_d = dec_pc_q + 32'(eff_take);
      count_d  = count_q + (fill ? CW'(FQ_WIN) : CW'(0)) - CW'(eff_take);
      if (over_take) begin
        take_err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset overriding everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      dec_pc_q   <= RESET_PC;
      take_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      dec_pc_q   <= dec_pc_d;
      take_err_q <= take_err_d;
    end
  end

  assign fetch_pc = fetch_pc_q;
  assign dec_pc   = dec_pc_q;
  assign take_err = take_err_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue against a memory image mem[k] = k.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised through prefill-to-full, over-take and redirect sequences.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic [39:0] fetch_instr;
  logic        fetch_en;
  logic [39:0] dec_bytes;
  logic [2:0]  dec_count;
  logic [31:0] dec_pc;
  logic [2:0]  dec_take;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        take_err;

  int vectors;
  int miscompares;

  fetch_queue #(
    .RESET_PC (32'h0),
    .DEPTH    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_en       (fetch_en),
    .dec_bytes      (dec_bytes),
    .dec_count      (dec_count),
    .dec_pc         (dec_pc),
    .dec_take       (dec_take),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .take_err       (take_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Five bytes of the image starting at pc: byte i is (pc + i) & 8'hFF.
  function automatic logic [39:0] win(input logic [31:0] pc);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = pc[7:0] + 8'(i);
    end
    return r;
  endfunction

  // Instruction memory: combinational read of the image.
  always_comb fetch_instr = win(fetch_pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    dec_take       = 3'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_dec_count", 40'(dec_count), 40'd0);
    check("rst_dec_bytes", dec_bytes, 40'h0);
    check("rst_dec_pc",    40'(dec_pc), 40'h0);
    check("rst_fetch_pc",  40'(fetch_pc), 40'h0);
    check("rst_take_err",  40'(take_err), 40'd0);

    // Prefill with no decode: fills at 0, 5, 10 then stalls at count 15
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    tick();
    check("fill1_fetch_pc",  40'(fetch_pc), 40'h5);
    check("fill1_dec_count", 40'(dec_count), 40'd5);
    check("fill1_dec_bytes", dec_bytes, 40'h0403020100);
    tick();
    check("fill2_fetch_pc",  40'(fetch_pc), 40'hA);
    tick();
    check("fill3_fetch_pc",  40'(fetch_pc), 40'hF);
    tick();
    tick();
    check("full_fetch_pc",   40'(fetch_pc), 40'hF);
    check("full_dec_bytes",  dec_bytes, 40'h0403020100);
    check("full_dec_count",  40'(dec_count), 40'd5);
    check("full_dec_pc",     40'(dec_pc), 40'h0);

    // Steady take of 3 bytes per cycle; fetch_pc sequence follows free-space stalls
    dec_take = 3'd3;
    begin
      logic [31:0] exp_fpc [8];
      exp_fpc = '{32'd15, 32'd15, 32'd20, 32'd25, 32'd25, 32'd30, 32'd30, 32'd35};
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("take3_dec_pc",    40'(dec_pc), 40'(3 * k));
        check("take3_dec_bytes", dec_bytes, win(32'(3 * k)));
        check("take3_dec_count", 40'(dec_count), 40'd5);
        check("take3_fetch_pc",  40'(fetch_pc), 40'(exp_fpc[k-1]));
      end
    end
    dec_take = 3'd0;
    tick();
    tick();
    check("refill_fetch_pc", 40'(fetch_pc), 40'd40);
    check("refill_dec_pc",   40'(dec_pc), 40'd24);

    // Redirect on a full queue with a concurrent take of 2
    redirect_valid = 1'b1;
    redirect_pc    = 32'h21;
    dec_take       = 3'd2;
    tick();
    check("redir_dec_count", 40'(dec_count), 40'd0);
    check("redir_fetch_pc",  40'(fetch_pc), 40'h21);
    check("redir_dec_pc",    40'(dec_pc), 40'h21);
    check("redir_dec_bytes", dec_bytes, 40'h0);
    check("redir_take_err",  40'(take_err), 40'd0);
    redirect_valid = 1'b0;
    dec_take       = 3'd0;
    tick();
    check("redir_fill_bytes", dec_bytes, 40'h2524232221);
    check("redir_fill_count", 40'(dec_count), 40'd5);

    // Over-consumption: leave 2 bytes, then ask for 5
    fetch_en = 1'b0;
    dec_take = 3'd3;
    tick();
    check("part_dec_count", 40'(dec_count), 40'd2);
    check("part_dec_bytes", dec_bytes, 40'h2524);
    check("part_take_err",  40'(take_err), 40'd0);
    dec_take = 3'd5;
    tick();
    check("over_dec_pc",    40'(dec_pc), 40'h26);
    check("over_dec_count", 40'(dec_count), 40'd0);
    check("over_take_err",  40'(take_err), 40'd1);
    dec_take = 3'd0;
    tick();
    tick();
    check("empty_dec_bytes", dec_bytes, 40'h0);
    check("empty_dec_pc",    40'(dec_pc), 40'h26);
    check("sticky_take_err", 40'(take_err), 40'd1);

    // Redirect to 0 keeps take_err; then continuous take of 5 for 40 cycles
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check("redir0_take_err", 40'(take_err), 40'd1);
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    dec_take       = 3'd5;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("take5_dec_count", 40'(dec_count), 40'd5);
      check("take5_dec_pc",    40'(dec_pc), 40'(5 * (k - 1)));
      check("take5_dec_bytes", dec_bytes, win(32'(5 * (k - 1))));
    end
    check("take5_fetch_pc", 40'(fetch_pc), 40'd200);
    check("take5_take_err", 40'(take_err), 40'd1);

    // Build count 12: one pure fill (5 -> 10), then fill with take 3 (10 -> 12)
    dec_take = 3'd0;
    tick();
    dec_take = 3'd3;
    tick();
    check("mid_dec_pc",    40'(dec_pc), 40'd198);
    check("mid_fetch_pc",  40'(fetch_pc), 40'd210);
    check("mid_dec_bytes", dec_bytes, win(32'd198));

    // Reset mid-stream overrides a concurrent redirect, fill and take
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h77;
    tick();
    check("mrst_dec_count", 40'(dec_count), 40'd0);
    check("mrst_fetch_pc",  40'(fetch_pc), 40'h0);
    check("mrst_dec_pc",    40'(dec_pc), 40'h0);
    check("mrst_take_err",  40'(take_err), 40'd0);
    check("mrst_dec_bytes", dec_bytes, 40'h0);
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    dec_take       = 3'd0;
    tick();
    check("post_rst_bytes",    dec_bytes, 40'h0403020100);
    check("post_rst_fetch_pc", 40'(fetch_pc), 40'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_queue
